// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD digit type, digit limits and load validation helper.
package bcd_pkg;
   typedef logic [3:0] bcd_digit_t;
   localparam bcd_digit_t BCD_MAX = 4'd9;
   localparam bcd_digit_t BCD_MIN = 4'd0;
   function automatic logic is_bcd(input bcd_digit_t d);
      return d <= BCD_MAX;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade counter with up/down step, carry/borrow out, sync clear and load.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_load,
   input  bcd_digit_t i_load_val,
   input  logic       i_step,
   input  logic       i_down,
   output bcd_digit_t o_digit,
   output logic       o_carry
);
   bcd_digit_t r_digit;
   logic       w_last;
   bcd_digit_t w_next;
   // w_last marks the digit that rolls over and hands a carry/borrow to the next decade
   always_comb begin
      w_last  = i_down ? (r_digit == BCD_MIN) : (r_digit == BCD_MAX);
      w_next  = w_last ? (i_down ? BCD_MAX : BCD_MIN) : (i_down ? r_digit - 4'd1 : r_digit + 4'd1);
      o_carry = i_step & w_last;
   end
   always_ff @(posedge clk) begin
      if (!rst_n)      r_digit <= BCD_MIN;
      else if (i_clr)  r_digit <= BCD_MIN;
      else if (i_load) r_digit <= i_load_val;
      else if (i_step) r_digit <= w_next;
   end
   assign o_digit = r_digit;
endmodule

// File: rtl/bcd_tick_counter.sv
// bcd_tick_counter: two-digit BCD counter stepped by a prescaled tick, with clear, load and pulses.
// Define BCD_DOWN_EN to honour DIR=1 as count down; otherwise DIR is ignored.
module bcd_tick_counter
   import bcd_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1
) (
   input  logic       CLOCK_50,
   input  logic       RESETN,
   input  logic       EN,
   input  logic       CLR,
   input  logic       LOAD,
   input  logic [7:0] LOAD_VAL,
   input  logic       DIR,
   output logic [3:0] DIGIT0,
   output logic [3:0] DIGIT1,
   output logic       TICK,
   output logic       WRAP,
   output logic       LOAD_ERR
);
   localparam int PRESCALE = CLK_HZ / TICK_HZ;
   localparam int PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   generate
      if (PRESCALE < 1) begin : g_bad_prescale
         $error("bcd_tick_counter: PRESCALE = CLK_HZ/TICK_HZ must be >= 1");
      end
   endgenerate
   logic [PW-1:0] r_pre;
   logic          r_tick, r_wrap, r_load_err;
   logic          w_pre_max, w_tick, w_load_ok, w_step, w_down, w_c0, w_c1;
`ifdef BCD_DOWN_EN
   assign w_down = DIR;
`else
   logic w_unused_dir;
   assign w_unused_dir = DIR;
   assign w_down = 1'b0;
`endif
   // a LOAD (accepted or rejected) or CLR swallows the count step of a coincident tick
   always_comb begin
      w_pre_max = (r_pre == PW'(PRESCALE - 1));
      w_tick    = EN & w_pre_max;
      w_load_ok = LOAD & is_bcd(LOAD_VAL[7:4]) & is_bcd(LOAD_VAL[3:0]);
      w_step    = w_tick & ~LOAD & ~CLR;
   end
   always_ff @(posedge CLOCK_50) begin
      if (!RESETN) begin
         r_pre      <= '0;
         r_tick     <= 1'b0;
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_pre      <= CLR ? '0 : (EN ? (w_pre_max ? '0 : r_pre + 1'b1) : r_pre);
         r_tick     <= w_tick & ~CLR;
         r_wrap     <= w_c1;
         r_load_err <= LOAD & ~w_load_ok & ~CLR;
      end
   end
   bcd_digit u_ones (
      .clk        (CLOCK_50),
      .rst_n      (RESETN),
      .i_clr      (CLR),
      .i_load     (w_load_ok),
      .i_load_val (LOAD_VAL[3:0]),
      .i_step     (w_step),
      .i_down     (w_down),
      .o_digit    (DIGIT0),
      .o_carry    (w_c0)
   );
   bcd_digit u_tens (
      .clk        (CLOCK_50),
      .rst_n      (RESETN),
      .i_clr      (CLR),
      .i_load     (w_load_ok),
      .i_load_val (LOAD_VAL[7:4]),
      .i_step     (w_c0),
      .i_down     (w_down),
      .o_digit    (DIGIT1),
      .o_carry    (w_c1)
   );
   assign TICK     = r_tick;
   assign WRAP     = r_wrap;
   assign LOAD_ERR = r_load_err;
endmodule

// File: tb/tb_bcd_tick_counter.sv
// tb_bcd_tick_counter: table-driven check of bcd_tick_counter with PRESCALE=10 plus hand sequences.
module tb_bcd_tick_counter;
   logic       clk = 1'b0;
   logic       resetn = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0, dir = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic [3:0] d0, d1;
   logic       tick, wrap, load_err;
   int         n_tests = 0, n_fail = 0;
   int         c_tick, c_wrap, c_err;

   typedef struct {
      logic       en, clr, load, dir;
      logic [7:0] val;
      int         n;
      logic [7:0] exp_dig;
      int         exp_tick, exp_wrap, exp_err;
   } vec_t;
   vec_t v[$];

   always #5 clk = ~clk;

   bcd_tick_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
      .CLOCK_50 (clk),
      .RESETN   (resetn),
      .EN       (en),
      .CLR      (clr),
      .LOAD     (load),
      .LOAD_VAL (load_val),
      .DIR      (dir),
      .DIGIT0   (d0),
      .DIGIT1   (d1),
      .TICK     (tick),
      .WRAP     (wrap),
      .LOAD_ERR (load_err)
   );

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic e, c, l, dr, input logic [7:0] val, input int n,
                      input logic [7:0] dig, input int t, w, er);
      vec_t x;
      x = '{en: e, clr: c, load: l, dir: dr, val: val, n: n, exp_dig: dig,
            exp_tick: t, exp_wrap: w, exp_err: er};
      v.push_back(x);
   endtask

   task automatic run(input int n);
      c_tick = 0; c_wrap = 0; c_err = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         c_tick += int'(tick);
         c_wrap += int'(wrap);
         c_err  += int'(load_err);
      end
   endtask

   initial begin
      //  en clr ld dir val    n    digits tick wrap err
      add(1, 0, 0, 0, 8'h00, 100, 8'h10, 10, 0, 0);
      add(1, 0, 1, 0, 8'h98,   1, 8'h98,  0, 0, 0);
      add(1, 0, 0, 0, 8'h00,  19, 8'h00,  2, 1, 0);
      add(0, 0, 1, 0, 8'h3A,   1, 8'h00,  0, 0, 1);
      add(0, 0, 1, 0, 8'h47,   1, 8'h47,  0, 0, 0);
      add(1, 0, 0, 0, 8'h00,   9, 8'h47,  0, 0, 0);
      add(1, 0, 1, 0, 8'h55,   1, 8'h55,  1, 0, 0);
      add(1, 0, 0, 0, 8'h00,   5, 8'h55,  0, 0, 0);
      add(0, 0, 0, 0, 8'h00,  25, 8'h55,  0, 0, 0);
      add(1, 0, 0, 0, 8'h00,   5, 8'h56,  1, 0, 0);
      add(1, 0, 0, 0, 8'h00,   9, 8'h56,  0, 0, 0);
      add(1, 1, 0, 0, 8'h00,   1, 8'h00,  0, 0, 0);
      add(1, 0, 0, 0, 8'h00,  10, 8'h01,  1, 0, 0);
      add(0, 0, 1, 0, 8'h00,   1, 8'h00,  0, 0, 0);
`ifdef BCD_DOWN_EN
      add(1, 0, 0, 1, 8'h00,  10, 8'h99,  1, 1, 0);
      add(1, 0, 0, 1, 8'h00,  10, 8'h98,  1, 0, 0);
      add(0, 0, 1, 0, 8'h10,   1, 8'h10,  0, 0, 0);
      add(1, 0, 0, 1, 8'h00,  10, 8'h09,  1, 0, 0);
`else
      add(1, 0, 0, 1, 8'h00,  10, 8'h01,  1, 0, 0);
      add(1, 0, 0, 1, 8'h00,  10, 8'h02,  1, 0, 0);
      add(0, 0, 1, 0, 8'h10,   1, 8'h10,  0, 0, 0);
      add(1, 0, 0, 1, 8'h00,  10, 8'h11,  1, 0, 0);
`endif
      add(0, 1, 1, 0, 8'h77,   1, 8'h00,  0, 0, 0);
      add(0, 0, 1, 0, 8'hA5,   1, 8'h00,  0, 0, 1);

      repeat (2) @(posedge clk);
      #1;
      check("reset_digits", int'({d1, d0}), 8'h00);
      check("reset_pulses", int'({tick, wrap, load_err}), 0);
      resetn = 1'b1;

      foreach (v[i]) begin
         en = v[i].en; clr = v[i].clr; load = v[i].load; dir = v[i].dir; load_val = v[i].val;
         run(v[i].n);
         check($sformatf("v%0d_digits", i), int'({d1, d0}), int'(v[i].exp_dig));
         check($sformatf("v%0d_ticks", i), c_tick, v[i].exp_tick);
         check($sformatf("v%0d_wraps", i), c_wrap, v[i].exp_wrap);
         check($sformatf("v%0d_load_err", i), c_err, v[i].exp_err);
      end
      en = 0; clr = 0; load = 0; dir = 0;

      // reset mid-count restarts the prescaler from 0
      en = 1; run(3);
      resetn = 1'b0; run(1);
      check("midreset_digits", int'({d1, d0}), 8'h00);
      check("midreset_pulses", int'({tick, wrap, load_err}), 0);
      resetn = 1'b1; run(9);
      check("midreset_no_early_tick", c_tick, 0);
      run(1);
      check("midreset_tick_at_10", int'(tick), 1);
      check("midreset_digits_01", int'({d1, d0}), 8'h01);

      // WRAP is a single cycle pulse aligned with the TICK of 99->00
      en = 0; load = 1; load_val = 8'h99; run(1);
      load = 0; en = 1;
      for (int k = 0; k < 12; k++) begin
         run(1);
         check($sformatf("wrap_cyc%0d", k), int'({tick, wrap}), (k == 9) ? 3 : 0);
      end
      check("wrap_final_digits", int'({d1, d0}), 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
